// File: rtl/right_shift_pipelined_stall.sv
// ----------------------------------------------------------------------------
// right_shift_pipelined_stall
//   Pipelined barrel right shifter with one radix-4 shift digit per stage,
//   logical or arithmetic fill, a sticky bit (OR of every discarded bit) and a
//   valid/ready handshake with a single global advance enable.
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous active-high reset
//   in        operand
//   shift     right-shift amount, 0..2^SW-1 (may exceed WIDTH-1)
//   arith     1 = fill with in[WIDTH-1], 0 = fill with zero
//   validIn   input beat valid
//   readyIn   block accepts a beat this cycle
//   out       shifted result
//   sticky    OR of the bits shifted out below the LSB
//   validOut  out/sticky valid
//   readyOut  consumer accepts the beat this cycle
// ----------------------------------------------------------------------------

// One radix-4 shift step: shifts right by dig_i * 4^S, filling with fill_i,
// and folds the dropped LSBs into the running sticky.
module right_shift_pipelined_stall_stage #(
   parameter int WIDTH = 13,
   parameter int S     = 0
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             stk_i,
   input  logic             fill_i,
   input  logic [1:0]       dig_i,
   output logic [WIDTH-1:0] data_o,
   output logic             stk_o
);
   localparam int AW = 2*S + 2;

   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] drop_mask;

   assign amt = AW'(dig_i) << (2*S);

   // Shifting a {fill, data} double-width word keeps the fill bits flowing in
   // from the top; amounts >= WIDTH leave only fill bits.
   assign data_o = WIDTH'({{WIDTH{fill_i}}, data_i} >> amt);

   // Low amt bits of the incoming data are the ones that fall off this step.
   assign drop_mask = ~({WIDTH{1'b1}} << amt);
   assign stk_o     = stk_i | (|(data_i & drop_mask));
endmodule

module right_shift_pipelined_stall #(
   parameter int WIDTH  = 13,
   parameter int SW     = $clog2(WIDTH),
   parameter int STAGES = ($clog2(WIDTH) + 1) / 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic [SW-1:0]    shift,
   input  logic             arith,
   input  logic             validIn,
   output logic             readyIn,
   output logic [WIDTH-1:0] out,
   output logic             sticky,
   output logic             validOut,
   input  logic             readyOut
);
   localparam int SPW = 2*STAGES;

   logic             en;
   logic             acc;
   logic [SPW-1:0]   shift_pad;
   logic [STAGES:1]  vld_pipe_q;

   // One enable for the whole pipe: everything moves when the output slot is
   // empty or being drained, otherwise everything holds.
   assign en        = ~validOut | readyOut;
   assign readyIn   = en;
   assign acc       = validIn & en;
   assign shift_pad = SPW'(shift);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   vld_pipe_q <= '0;
      else if (en) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], acc};
   end

   // Rank i applies digit S = STAGES-1-i (most significant digit first). Only
   // the digits still to be applied, and the fill bit, travel to later ranks.
   for (genvar i = 0; i < STAGES; i++) begin : g_rank
      localparam int S = STAGES - 1 - i;

      logic [WIDTH-1:0] data_in, data_d, data_q;
      logic             stk_in, stk_d, stk_q, fill_in;
      logic [1:0]       dig;

      if (i == 0) begin : g_src
         assign data_in = in;
         assign stk_in  = 1'b0;
         assign fill_in = arith & in[WIDTH-1];
         assign dig     = shift_pad[2*S+1:2*S];
      end else begin : g_src
         assign data_in = g_rank[i-1].data_q;
         assign stk_in  = g_rank[i-1].stk_q;
         assign fill_in = g_rank[i-1].g_mid.fill_q;
         assign dig     = g_rank[i-1].g_mid.rem_q[2*S+1:2*S];
      end

      right_shift_pipelined_stall_stage #(.WIDTH(WIDTH), .S(S)) u_stage (
         .data_i (data_in),
         .stk_i  (stk_in),
         .fill_i (fill_in),
         .dig_i  (dig),
         .data_o (data_d),
         .stk_o  (stk_d)
      );

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            data_q <= '0;
            stk_q  <= 1'b0;
         end else if (en) begin
            data_q <= data_d;
            stk_q  <= stk_d;
         end
      end

      if (S > 0) begin : g_mid
         logic             fill_q;
         logic [2*S-1:0]   rem_q, rem_d;

         if (i == 0) begin : g_rem
            assign rem_d = shift_pad[2*S-1:0];
         end else begin : g_rem
            assign rem_d = g_rank[i-1].g_mid.rem_q[2*S-1:0];
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               fill_q <= 1'b0;
               rem_q  <= '0;
            end else if (en) begin
               fill_q <= fill_in;
               rem_q  <= rem_d;
            end
         end
      end
   end

   assign out      = g_rank[STAGES-1].data_q;
   assign sticky   = g_rank[STAGES-1].stk_q;
   assign validOut = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_right_shift_pipelined_stall.sv
module tb_right_shift_pipelined_stall;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] din = '0;
  logic [3:0]  shift = '0;
  logic        arith = 1'b0;
  logic        validIn = 1'b0;
  logic        readyOut = 1'b1;
  logic        readyIn, sticky, validOut;
  logic [12:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  right_shift_pipelined_stall dut (
    .clk      (clk),
    .reset    (reset),
    .in       (din),
    .shift    (shift),
    .arith    (arith),
    .validIn  (validIn),
    .readyIn  (readyIn),
    .out      (dout),
    .sticky   (sticky),
    .validOut (validOut),
    .readyOut (readyOut)
  );

  function automatic logic [13:0] golden(input logic [12:0] d, input logic [3:0] sh,
                                         input logic a);
    logic signed [12:0] sd;
    logic [12:0]        o;
    logic               s;
    sd = d;
    if (a) o = sd >>> sh;
    else   o = d >> sh;
    s = 1'b0;
    for (int b = 0; b < 13; b++) if (b < int'(sh)) s = s | d[b];
    return {s, o};
  endfunction

  task automatic drive_beat(input logic [12:0] d, input logic [3:0] sh, input logic a);
    din = d; shift = sh; arith = a; validIn = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if ({validOut, sticky, dout} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b s=%b out=%h want 0 0 0000", validOut, sticky, dout);
    end
    #9 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (readyIn !== 1'b1 || validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got readyIn=%b validOut=%b want 1 0", readyIn, validOut);
    end
  endtask

  task automatic test_logical;
    @(negedge clk); drive_beat(13'h1ABC, 4'd4, 1'b0);
    @(negedge clk); validIn = 1'b0;
    n_tests++;
    if (validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL logical_early: got validOut=%b want 0", validOut);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h01AB || sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL logical: got v=%b out=%h s=%b want 1 01ab 1", validOut, dout, sticky);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL logical_one_cycle: got validOut=%b want 0", validOut);
    end
  endtask

  task automatic test_arith;
    @(negedge clk); drive_beat(13'h1000, 4'd3, 1'b1);
    @(negedge clk); drive_beat(13'h1000, 4'd3, 1'b0);
    @(negedge clk); validIn = 1'b0;
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h1E00 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL arith_fill: got v=%b out=%h s=%b want 1 1e00 0", validOut, dout, sticky);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h0200 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL arith_off: got v=%b out=%h s=%b want 1 0200 0", validOut, dout, sticky);
    end
    @(negedge clk);
  endtask

  task automatic test_oversize;
    @(negedge clk); drive_beat(13'h0001, 4'd15, 1'b0);
    @(negedge clk); drive_beat(13'h1000, 4'd15, 1'b1);
    @(negedge clk); validIn = 1'b0;
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h0000 || sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_logical: got v=%b out=%h s=%b want 1 0000 1", validOut, dout, sticky);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h1FFF || sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_arith: got v=%b out=%h s=%b want 1 1fff 1", validOut, dout, sticky);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    @(negedge clk); readyOut = 1'b0; drive_beat(13'h0F0F, 4'd1, 1'b0);
    #1;
    n_tests++;
    if (readyIn !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept_a: got readyIn=%b want 1", readyIn);
    end
    @(negedge clk); drive_beat(13'h1234, 4'd2, 1'b1);
    #1;
    n_tests++;
    if (readyIn !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept_b: got readyIn=%b want 1", readyIn);
    end
    @(negedge clk); validIn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (validOut !== 1'b1 || dout !== 13'h0787 || sticky !== 1'b1 || readyIn !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_a: cycle %0d got v=%b out=%h s=%b rdy=%b want 1 0787 1 0",
                 k, validOut, dout, sticky, readyIn);
      end
      @(negedge clk);
    end
    readyOut = 1'b1;
    #1;
    n_tests++;
    if (readyIn !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got readyIn=%b want 1", readyIn);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h1C8D || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_b: got v=%b out=%h s=%b want 1 1c8d 0", validOut, dout, sticky);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: got validOut=%b want 0", validOut);
    end
  endtask

  task automatic test_stream;
    logic [13:0] exp_q[$];
    logic [13:0] e;
    logic [13:0] held;
    logic        hold_pending;
    int          sent, cyc;
    sent = 0; cyc = 0; hold_pending = 1'b0; held = '0;
    while ((sent < 100 || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      if (hold_pending) begin
        n_tests++;
        if (validOut !== 1'b1 || {sticky, dout} !== held) begin
          n_fail++;
          $display("FAIL stream_stall_stable: got v=%b out=%h s=%b want 1 %h %b",
                   validOut, dout, sticky, held[12:0], held[13]);
        end
      end
      readyOut = ($urandom_range(0, 3) != 0);
      validIn  = (sent < 100) && ($urandom_range(0, 2) != 0);
      din      = 13'($urandom);
      shift    = 4'($urandom);
      arith    = 1'($urandom);
      #1;
      if (validOut && readyOut) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_spurious: got out=%h with nothing expected", dout);
        end else begin
          e = exp_q.pop_front();
          if ({sticky, dout} !== e) begin
            n_fail++;
            $display("FAIL stream_data: got out=%h s=%b want %h %b", dout, sticky, e[12:0], e[13]);
          end
        end
      end
      hold_pending = validOut && !readyOut;
      held = {sticky, dout};
      if (validIn && readyIn) begin
        exp_q.push_back(golden(din, shift, arith));
        sent++;
      end
      cyc++;
    end
    validIn = 1'b0; readyOut = 1'b1;
    n_tests++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL stream_timeout: got %0d beats sent, %0d pending want all drained", sent, exp_q.size());
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_extra: got validOut=%b want 0", validOut);
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk); drive_beat(13'h1FFF, 4'd0, 1'b0);
    @(negedge clk); drive_beat(13'h0F00, 4'd4, 1'b0);
    @(negedge clk); validIn = 1'b0;
    n_tests++;
    if (validOut !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_inflight: got validOut=%b want 1", validOut);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (validOut !== 1'b0 || dout !== 13'h0000 || sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b out=%h s=%b want 0 0000 0", validOut, dout, sticky);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_beat(13'h0ABC, 4'd8, 1'b0);
    #1;
    n_tests++;
    if (readyIn !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_ready: got readyIn=%b want 1", readyIn);
    end
    @(negedge clk); validIn = 1'b0;
    n_tests++;
    if (validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_stale: got validOut=%b want 0", validOut);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b1 || dout !== 13'h000A || sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_new: got v=%b out=%h s=%b want 1 000a 1", validOut, dout, sticky);
    end
    @(negedge clk);
    n_tests++;
    if (validOut !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drained: got validOut=%b want 0", validOut);
    end
  endtask

  initial begin
    test_reset;
    test_logical;
    test_arith;
    test_oversize;
    test_backpressure;
    test_stream;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
